// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory access arbiter: FSM states and requester IDs.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2,
    REJECT   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  // Memory is word organised; byte lanes [1:0] must be zero for a legal access.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Priority select between CPU and DMA with a registered starvation counter.
// Latency: winner is combinational from reqs; counter updates on the grant edge.
// Backpressure: none; losers simply keep their req asserted until selected.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cpu_req,
  input  logic    dma_req,
  input  logic    grant_evt,
  output logic    win_vld,
  output req_id_e win_id
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  // CPU wins ties unless the DMA has already waited through STARVE_MAX CPU grants.
  always_comb begin
    win_vld = cpu_req | dma_req;
    win_id  = REQ_CPU;
    if (dma_req && (!cpu_req || (starve_cnt_q == STARVE_LIM))) begin
      win_id = REQ_DMA;
    end
  end

  // Count CPU grants taken while the DMA waits; any DMA grant or idle DMA clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req) begin
      starve_cnt_d = '0;
    end else if (grant_evt) begin
      if (win_id == REQ_DMA) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_LIM) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a DMA/debug port.
// Latency: strobe from grant edge k, done pulse after edge k+LAT; one access per LAT+2 cycles.
// Backpressure: requester holds req until its done/err; the loser waits with req held.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int  SIZE_WARD  = 2,
  parameter int  READ_LAT   = 2,
  parameter int  WRITE_LAT  = 2,
  parameter int  STARVE_MAX = 4,
  localparam int ADDR_W     = $clog2(4 * SIZE_WARD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_done,
  output logic              dma_done,
  output logic              cpu_err,
  output logic              dma_err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [31:0]       mem_read_data,
  output logic              busy
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [LAT_W-1:0] RD_INIT = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0] WR_INIT = LAT_W'(WRITE_LAT - 1);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_write_data_q, mem_write_data_d;
  logic              mem_memread_q, mem_memread_d;
  logic              mem_memwrite_q, mem_memwrite_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dma_done_q, dma_done_d;
  logic              cpu_err_q, cpu_err_d;
  logic              dma_err_q, dma_err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              win_vld;
  req_id_e           win_id;
  logic              grant_evt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;

  dmem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .grant_evt (grant_evt),
    .win_vld   (win_vld),
    .win_id    (win_id)
  );

  // Route the winning requester's access fields.
  always_comb begin
    w_we    = cpu_we;
    w_addr  = cpu_addr;
    w_wdata = cpu_wdata;
    if (win_id == REQ_DMA) begin
      w_we    = dma_we;
      w_addr  = dma_addr;
      w_wdata = dma_wdata;
    end
  end

  // Access FSM: grant or reject in IDLE, count memory latency in ACCESS, one dead cycle after.
  always_comb begin
    state_d          = state_q;
    lat_cnt_d        = lat_cnt_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_memread_d    = mem_memread_q;
    mem_memwrite_d   = mem_memwrite_q;
    cpu_gnt_d        = cpu_gnt_q;
    dma_gnt_d        = dma_gnt_q;
    cpu_done_d       = 1'b0;
    dma_done_d       = 1'b0;
    cpu_err_d        = 1'b0;
    dma_err_d        = 1'b0;
    rdata_d          = rdata_q;
    grant_evt        = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_evt = 1'b1;
          if (is_word_aligned(w_addr[1:0])) begin
            state_d          = ACCESS;
            mem_address_d    = w_addr;
            mem_write_data_d = w_wdata;
            mem_memwrite_d   = w_we;
            mem_memread_d    = !w_we;
            cpu_gnt_d        = (win_id == REQ_CPU);
            dma_gnt_d        = (win_id == REQ_DMA);
            lat_cnt_d        = w_we ? WR_INIT : RD_INIT;
          end else begin
            state_d   = REJECT;
            cpu_err_d = (win_id == REQ_CPU);
            dma_err_d = (win_id == REQ_DMA);
          end
        end
      end
      ACCESS: begin
        if (lat_cnt_q == '0) begin
          if (mem_memread_q) begin
            rdata_d = mem_read_data;
          end
          mem_memread_d  = 1'b0;
          mem_memwrite_d = 1'b0;
          cpu_gnt_d      = 1'b0;
          dma_gnt_d      = 1'b0;
          cpu_done_d     = cpu_gnt_q;
          dma_done_d     = dma_gnt_q;
          state_d        = COMPLETE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      COMPLETE: state_d = IDLE;
      REJECT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight access silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      lat_cnt_q        <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      cpu_gnt_q        <= 1'b0;
      dma_gnt_q        <= 1'b0;
      cpu_done_q       <= 1'b0;
      dma_done_q       <= 1'b0;
      cpu_err_q        <= 1'b0;
      dma_err_q        <= 1'b0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      lat_cnt_q        <= lat_cnt_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_memread_q    <= mem_memread_d;
      mem_memwrite_q   <= mem_memwrite_d;
      cpu_gnt_q        <= cpu_gnt_d;
      dma_gnt_q        <= dma_gnt_d;
      cpu_done_q       <= cpu_done_d;
      dma_done_q       <= dma_done_d;
      cpu_err_q        <= cpu_err_d;
      dma_err_q        <= dma_err_d;
      rdata_q          <= rdata_d;
    end
  end

  assign cpu_gnt        = cpu_gnt_q;
  assign dma_gnt        = dma_gnt_q;
  assign cpu_done       = cpu_done_q;
  assign dma_done       = dma_done_q;
  assign cpu_err        = cpu_err_q;
  assign dma_err        = dma_err_q;
  assign rdata          = rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign busy           = (state_q != IDLE);

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_memread_q && mem_memwrite_q));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({cpu_gnt_q, dma_gnt_q}));
  a_cpu_done_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    cpu_done_q |-> $past(cpu_gnt_q));
  a_dma_done_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    dma_done_q |-> $past(dma_gnt_q));
  // A requester dropping req while its access is still in flight breaks the handshake.
  a_cpu_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ACCESS && cpu_gnt_q) |-> cpu_req);
  a_dma_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ACCESS && dma_gnt_q) |-> dma_req);

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a word memory model of fixed write latency.
// Latency: checks strobe/done timing cycle by cycle against hand-computed values.
// Backpressure: bench requesters hold req until done/err, then drop it for one cycle.
module tb_dmem_access_arbiter;

  localparam int SIZE_WARD = 2;
  localparam int WRITE_LAT = 2;
  localparam int ADDR_W    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic              dma_req = 1'b0, dma_we = 1'b0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [31:0]       dma_wdata = '0;
  logic              cpu_gnt, dma_gnt, cpu_done, dma_done, cpu_err, dma_err;
  logic [31:0]       rdata, mem_write_data, mem_read_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_memread, mem_memwrite, busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [SIZE_WARD];
  bit          seeded = 1'b0;
  int          wcnt;

  always #5 clk = ~clk;

  dmem_access_arbiter #(
    .SIZE_WARD (SIZE_WARD), .READ_LAT (2), .WRITE_LAT (WRITE_LAT), .STARVE_MAX (4)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
    .dma_req (dma_req), .dma_we (dma_we), .dma_addr (dma_addr), .dma_wdata (dma_wdata),
    .cpu_gnt (cpu_gnt), .dma_gnt (dma_gnt), .cpu_done (cpu_done), .dma_done (dma_done),
    .cpu_err (cpu_err), .dma_err (dma_err), .rdata (rdata),
    .mem_address (mem_address), .mem_write_data (mem_write_data),
    .mem_memread (mem_memread), .mem_memwrite (mem_memwrite),
    .mem_read_data (mem_read_data), .busy (busy)
  );

  // Read data is only meaningful while memread is asserted.
  assign mem_read_data = mem_memread ? mem[mem_address[ADDR_W-1:2]] : 32'hBAD0BAD0;

  // Memory model: a write lands only after memwrite has been held WRITE_LAT cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      if (!seeded) begin
        mem[0] <= 32'h11111111;
        mem[1] <= 32'h22222222;
        seeded <= 1'b1;
      end
    end else if (mem_memwrite) begin
      if (wcnt == WRITE_LAT - 1) begin
        mem[mem_address[ADDR_W-1:2]] <= mem_write_data;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit is_dma, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
    bit ok = 1'b0;
    rd = '0;
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (is_dma ? dma_done : cpu_done) begin
        rd = rdata;
        ok = 1'b1;
        break;
      end
    end
    if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
    if (!ok) check("access_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] seq;
    int          ngr;
    logic        pc, pd;
    bit          seen;

    // Reset state
    step(); step();
    check("rst_ctrl", {23'd0, cpu_gnt, dma_gnt, cpu_done, dma_done, cpu_err, dma_err,
                       mem_memread, mem_memwrite, busy}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", {29'd0, mem_address}, 32'd0);
    rst_n = 1'b1;
    step();

    // Reset mid-ACCESS write aborts it without touching memory
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'h4; cpu_wdata = 32'hCAFEF00D;
    step();
    check("abort_pre_wr", {31'd0, mem_memwrite}, 32'd1);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("abort_ctrl", {23'd0, cpu_gnt, dma_gnt, cpu_done, dma_done, cpu_err, dma_err,
                         mem_memread, mem_memwrite, busy}, 32'd0);
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mem", mem[1], 32'h22222222);
    rst_n = 1'b1;
    step();

    // CPU write DEADBEEF @4: memwrite two cycles, done after edge k+2
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'h4; cpu_wdata = 32'hDEADBEEF;
    step();
    check("wr_c0", {28'd0, cpu_gnt, mem_memwrite, mem_memread, cpu_done}, 32'b1100);
    check("wr_addr", {29'd0, mem_address}, 32'h4);
    step();
    check("wr_c1", {28'd0, cpu_gnt, mem_memwrite, mem_memread, cpu_done}, 32'b1100);
    step();
    check("wr_c2", {28'd0, cpu_gnt, mem_memwrite, busy, cpu_done}, 32'b0011);
    cpu_req = 1'b0;
    check("wr_mem", mem[1], 32'hDEADBEEF);
    step();
    check("wr_c3", {30'd0, busy, cpu_done}, 32'b00);

    // CPU read back @4
    cpu_req = 1'b1; cpu_we = 1'b0;
    step();
    check("rd_c0", {29'd0, cpu_gnt, mem_memread, mem_memwrite}, 32'b110);
    step();
    check("rd_c1_done", {31'd0, cpu_done}, 32'd0);
    step();
    check("rd_c2_done", {31'd0, cpu_done}, 32'd1);
    check("rd_data", rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    step();

    // Both request continuously: CPU x4, DMA, CPU x4, DMA
    cpu_we = 1'b0; cpu_addr = 3'h0; dma_we = 1'b0; dma_addr = 3'h0;
    cpu_req = 1'b1; dma_req = 1'b1;
    seq = '0; ngr = 0; pc = 1'b0; pd = 1'b0;
    for (int cyc = 0; cyc < 200 && ngr < 10; cyc++) begin
      step();
      if (cpu_gnt && !pc) begin seq[ngr] = 1'b0; ngr++; end
      if (dma_gnt && !pd) begin seq[ngr] = 1'b1; ngr++; end
      pc = cpu_gnt; pd = dma_gnt;
      cpu_req = !cpu_done;
      dma_req = !dma_done;
    end
    cpu_req = 1'b0;
    check("starve_ngr", ngr, 32'd10);
    check("starve_seq", {16'd0, seq}, 32'h0210);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = dma_done;
    end
    check("starve_dma_done", {31'd0, seen}, 32'd1);
    dma_req = 1'b0;
    step();

    // Simultaneous request with a fresh counter: CPU first, DMA after COMPLETE
    cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
    step();
    check("tie_c0", {30'd0, cpu_gnt, dma_gnt}, 32'b10);
    step();
    check("tie_c1", {30'd0, cpu_gnt, dma_gnt}, 32'b10);
    step();
    check("tie_c2", {30'd0, cpu_done, dma_gnt}, 32'b10);
    cpu_req = 1'b0;
    step();
    check("tie_c3", {31'd0, dma_gnt}, 32'd0);
    step();
    check("tie_c4", {31'd0, dma_gnt}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = dma_done;
    end
    check("tie_dma_done", {31'd0, seen}, 32'd1);
    dma_req = 1'b0;
    step();

    // Misaligned CPU address 0x6 is rejected with no memory strobe
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'h6;
    step();
    check("rej_c0", {27'd0, cpu_err, mem_memread, mem_memwrite, cpu_gnt, busy}, 32'b10001);
    cpu_req = 1'b0;
    step();
    check("rej_c1", {28'd0, cpu_err, cpu_done, mem_memread, busy}, 32'd0);
    step();
    check("rej_c2", {30'd0, cpu_done, mem_memread}, 32'd0);

    // DMA write then read of the top word, no wrap
    access(1'b1, 1'b1, 3'h4, 32'h01234567, rd);
    check("top_mem", mem[1], 32'h01234567);
    check("top_mem0", mem[0], 32'h11111111);
    access(1'b1, 1'b0, 3'h4, 32'h0, rd);
    check("top_rd", rd, 32'h01234567);
    check("top_rdata_hold", rdata, 32'h01234567);
    check("top_addr", {29'd0, mem_address}, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
